// File: rtl/fft_spectrum_reader.sv
// Display-side reader for the ping-pong FFT result memory: loads |re|+|im| bar heights
// once per frame and renders a bar graph. Optional peak markers under PEAK_HOLD_EN.
module fft_spectrum_reader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned BAR_W       = 10,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bank_ready,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_r,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [9:0]            px_x,
  input  logic [9:0]            px_y,
  output logic                  pixel_on,
  output logic                  pixel_peak
);

  localparam int unsigned N_BINS = 2 ** ADDR_WIDTH;
  localparam int unsigned MAG_W  = DATA_WIDTH + 1;
  localparam int unsigned HW     = DATA_WIDTH + SCALE_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(N_BINS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_start;
  logic                  r_ready;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_height [N_BINS];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start && (r_ready || bank_ready)) begin
          w_next  = S_LOAD;
          w_start = 1'b1;
        end
      end
      S_LOAD: begin
        if (r_vld && (r_wr_addr == LAST_BIN)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address issue and one-cycle-late write tag for the registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      load_done <= 1'b0;
      mem_addr  <= '0;
      r_ready   <= 1'b0;
      r_cnt     <= '0;
      r_vld     <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      busy      <= (w_next == S_LOAD);
      load_done <= (w_next == S_DONE);
      if (w_start)         r_ready <= 1'b0;
      else if (bank_ready) r_ready <= 1'b1;
      r_vld     <= (r_state == S_LOAD) && !r_cnt[ADDR_WIDTH];
      r_wr_addr <= mem_addr;
      if (w_start) begin
        mem_addr <= '0;
        r_cnt    <= '0;
      end else if ((r_state == S_LOAD) && !r_cnt[ADDR_WIDTH]) begin
        r_cnt <= r_cnt + 1'b1;
        if (mem_addr != LAST_BIN) mem_addr <= mem_addr + 1'b1;
      end
    end
  end

  logic [MAG_W-1:0]      w_re_ext;
  logic [MAG_W-1:0]      w_im_ext;
  logic [MAG_W-1:0]      w_abs_re;
  logic [MAG_W-1:0]      w_abs_im;
  logic [MAG_W-1:0]      w_sum;
  logic [DATA_WIDTH-1:0] w_mag;

  // Sum of absolutes fits MAG_W bits exactly; only the top value needs clamping.
  always_comb begin
    w_re_ext = {mem_data_r[DATA_WIDTH-1], mem_data_r};
    w_im_ext = {mem_data_i[DATA_WIDTH-1], mem_data_i};
    w_abs_re = w_re_ext[MAG_W-1] ? (~w_re_ext + 1'b1) : w_re_ext;
    w_abs_im = w_im_ext[MAG_W-1] ? (~w_im_ext + 1'b1) : w_im_ext;
    w_sum    = w_abs_re + w_abs_im;
    w_mag    = w_sum[MAG_W-1] ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BINS; i++) r_height[i] <= '0;
    end else if (r_vld) begin
      r_height[r_wr_addr] <= w_mag;
    end
  end

  logic [9:0]            w_bin;
  logic [9:0]            w_h;
  logic                  w_in;
  logic [ADDR_WIDTH-1:0] w_sel;
  logic [HW-1:0]         w_hgt_scaled;

  always_comb begin
    w_bin        = 10'(px_x / 10'(BAR_W));
    w_h          = 10'(V_ACTIVE - 1) - px_y;
    w_in         = (w_bin < 10'(N_BINS)) && (px_y < 10'(V_ACTIVE));
    w_sel        = w_bin[ADDR_WIDTH-1:0];
    w_hgt_scaled = HW'(r_height[w_sel]) << SCALE_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) pixel_on <= 1'b0;
    else     pixel_on <= w_in && (32'(w_h) < 32'(w_hgt_scaled));
  end

`ifdef PEAK_HOLD_EN
  logic [DATA_WIDTH-1:0] r_peak [N_BINS];
  logic [DATA_WIDTH-1:0] w_pk_dec;
  logic [HW-1:0]         w_pk_scaled;
  logic                  w_decay;

  always_comb begin
    w_pk_dec    = (r_peak[r_wr_addr] == '0) ? '0 : (r_peak[r_wr_addr] - 1'b1);
    w_pk_scaled = HW'(r_peak[w_sel]) << SCALE_SHIFT;
    w_decay     = (r_state == S_IDLE) && frame_start && !w_start;
  end

  // Peaks fall one step per frame and are pushed back up by fresh heights.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BINS; i++) r_peak[i] <= '0;
    end else if (r_vld) begin
      r_peak[r_wr_addr] <= (w_mag > w_pk_dec) ? w_mag : w_pk_dec;
    end else if (w_decay) begin
      for (int i = 0; i < N_BINS; i++)
        if (r_peak[i] != '0) r_peak[i] <= r_peak[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pixel_peak <= 1'b0;
    else     pixel_peak <= w_in && (32'(w_h) == 32'(w_pk_scaled));
  end
`else
  assign pixel_peak = 1'b0;
`endif

endmodule
